// File: rtl/config_sram_pkg.sv
// rtl/config_sram_pkg.sv - shared types and constants for the configuration SRAM sequencer
package config_sram_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_READ   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_WRITE  = 2'd3
    } seq_state_t;

    localparam logic [20:0] DEFAULT_BASE_ADDR = 21'h008FD5;
    localparam int          IDX_W             = 4;

endpackage

// File: rtl/cfg_slot_timer.sv
// rtl/cfg_slot_timer.sv - loadable down-counter timing settle, read and write slots
module cfg_slot_timer #(
    parameter int               CNT_W      = 5,
    parameter int               ACC_CYCLES = 2,
    parameter logic [CNT_W-1:0] RST_VAL    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             slot_last,
    output logic             we_window
);

    localparam logic [CNT_W-1:0] ACC_V = CNT_W'(ACC_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A write slot loads ACC_CYCLES+1: strobe spans counts ACC_CYCLES..1, leaving setup and hold cycles.
    assign slot_last = (cnt_q == '0);
    assign we_window = (cnt_q != '0) && (cnt_q <= ACC_V);

endmodule

// File: rtl/config_sram_sequencer.sv
// rtl/config_sram_sequencer.sv - boot-read / save-write sequencer owning the configuration SRAM port
module config_sram_sequencer
    import config_sram_pkg::*;
#(
    parameter logic [20:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          NBYTES     = 4,
    parameter int          SETTLE     = 16,
    parameter int          ACC_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [20:0]           sram_addr_in,
    input  logic                  sram_we_n_in,
    input  logic [7:0]            sram_dout_in,
    input  logic [7:0]            din,
    output logic [20:0]           sram_addr_out,
    output logic                  sram_we_n_out,
    output logic [7:0]            sram_dout_out,
    input  logic                  save_req,
    input  logic [8*NBYTES-1:0]   save_data,
    output logic [8*NBYTES-1:0]   config_out,
    output logic                  pwon_reset,
    output logic                  busy,
    output logic                  save_done,
    output logic                  vga_on,
    output logic                  scanlines_on
);

    localparam int CW      = 8 * NBYTES;
    localparam int CNT_MAX = (SETTLE > ACC_CYCLES + 2) ? SETTLE : ACC_CYCLES + 2;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] RD_LOAD     = CNT_W'(ACC_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD     = CNT_W'(ACC_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NBYTES - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pending_q, pending_d;
    logic             save_done_q, save_done_d;
    logic [CW-1:0]    snap_q, snap_d;
    logic [CW-1:0]    cfg_q, cfg_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             slot_last;
    logic             we_window;
    logic             save_start;
    logic             last_byte;
    logic [7:0]       snap_byte;

    cfg_slot_timer #(
        .CNT_W      (CNT_W),
        .ACC_CYCLES (ACC_CYCLES),
        .RST_VAL    (SETTLE_LOAD)
    ) u_slot_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .load_val  (tmr_load_val),
        .slot_last (slot_last),
        .we_window (we_window)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        cfg_d        = cfg_q;
        save_done_d  = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        save_start   = (state_q == ST_IDLE) && pending_q;
        last_byte    = (idx_q == LAST_IDX);
        // A request landing on the cycle a save starts stays pending for one more save.
        pending_d    = (pending_q && !save_start) || save_req;

        case (state_q)
            ST_SETTLE: begin
                if (slot_last) begin
                    state_d      = ST_READ;
                    idx_d        = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = RD_LOAD;
                end
            end
            ST_READ: begin
                if (slot_last) begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            cfg_d[8*i +: 8] = din;
                        end
                    end
                    if (last_byte) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d        = idx_q + 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = RD_LOAD;
                    end
                end
            end
            ST_IDLE: begin
                if (save_start) begin
                    state_d      = ST_WRITE;
                    idx_d        = '0;
                    snap_d       = save_data;
                    cfg_d        = save_data;
                    tmr_load     = 1'b1;
                    tmr_load_val = WR_LOAD;
                end
            end
            ST_WRITE: begin
                if (slot_last) begin
                    if (last_byte) begin
                        state_d     = ST_IDLE;
                        idx_d       = '0;
                        save_done_d = 1'b1;
                    end else begin
                        idx_d        = idx_q + 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = WR_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_SETTLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SETTLE;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            save_done_q <= 1'b0;
            snap_q      <= '0;
            cfg_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            save_done_q <= save_done_d;
            snap_q      <= snap_d;
            cfg_q       <= cfg_d;
        end
    end

    always_comb begin
        snap_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                snap_byte = snap_q[8*i +: 8];
            end
        end
    end

    // Outputs depend only on registered state, so reset forces we_n high without waiting for a clock.
    always_comb begin
        if (state_q == ST_IDLE) begin
            sram_addr_out = sram_addr_in;
            sram_we_n_out = sram_we_n_in;
            sram_dout_out = sram_dout_in;
        end else begin
            sram_addr_out = BASE_ADDR + 21'(idx_q);
            sram_we_n_out = (state_q == ST_WRITE) ? !we_window : 1'b1;
            sram_dout_out = snap_byte;
        end
    end

    assign config_out   = cfg_q;
    assign busy         = (state_q != ST_IDLE);
    assign pwon_reset   = (state_q == ST_SETTLE) || (state_q == ST_READ);
    assign save_done    = save_done_q;
    assign vga_on       = cfg_q[0];
    assign scanlines_on = cfg_q[1];

endmodule

// File: tb/tb_config_sram_sequencer.sv
// tb/tb_config_sram_sequencer.sv - directed bench for the configuration SRAM sequencer
module tb_config_sram_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [20:0] sram_addr_in = '0;
    logic        sram_we_n_in = 1'b1;
    logic [7:0]  sram_dout_in = '0;
    logic        save_req = 1'b0;
    logic [31:0] save_data = '0;

    logic [7:0]  din;
    logic [20:0] sram_addr_out;
    logic        sram_we_n_out;
    logic [7:0]  sram_dout_out;
    logic [31:0] config_out;
    logic        pwon_reset, busy, save_done, vga_on, scanlines_on;

    logic [7:0]  w_din = '0;
    logic        w_save_req = 1'b0;
    logic [31:0] w_save_data = '0;
    logic [20:0] w_addr_out;
    logic        w_we_n_out;
    logic [7:0]  w_dout_out;
    logic [31:0] w_config_out;
    logic        w_pwon_reset, w_busy, w_save_done, w_vga_on, w_scanlines_on;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [20:0] a);
        case (a)
            21'h008FD5: return 8'h03;
            21'h008FD6: return 8'hA5;
            21'h008FD7: return 8'h5A;
            21'h008FD8: return 8'hFF;
            default:    return 8'h00;
        endcase
    endfunction

    assign din = rom(sram_addr_out);

    config_sram_sequencer u_dut (
        .clk           (clk),
        .rst           (rst),
        .sram_addr_in  (sram_addr_in),
        .sram_we_n_in  (sram_we_n_in),
        .sram_dout_in  (sram_dout_in),
        .din           (din),
        .sram_addr_out (sram_addr_out),
        .sram_we_n_out (sram_we_n_out),
        .sram_dout_out (sram_dout_out),
        .save_req      (save_req),
        .save_data     (save_data),
        .config_out    (config_out),
        .pwon_reset    (pwon_reset),
        .busy          (busy),
        .save_done     (save_done),
        .vga_on        (vga_on),
        .scanlines_on  (scanlines_on)
    );

    config_sram_sequencer #(.BASE_ADDR(21'h1FFFFE), .NBYTES(4)) u_wrap (
        .clk           (clk),
        .rst           (rst),
        .sram_addr_in  (sram_addr_in),
        .sram_we_n_in  (sram_we_n_in),
        .sram_dout_in  (sram_dout_in),
        .din           (w_din),
        .sram_addr_out (w_addr_out),
        .sram_we_n_out (w_we_n_out),
        .sram_dout_out (w_dout_out),
        .save_req      (w_save_req),
        .save_data     (w_save_data),
        .config_out    (w_config_out),
        .pwon_reset    (w_pwon_reset),
        .busy          (w_busy),
        .save_done     (w_save_done),
        .vga_on        (w_vga_on),
        .scanlines_on  (w_scanlines_on)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge where rst has just been released; returns in cycle 25.
    task automatic boot_check();
        logic [20:0] wrap_tab [4];
        int k;
        wrap_tab[0] = 21'h1FFFFE;
        wrap_tab[1] = 21'h1FFFFF;
        wrap_tab[2] = 21'h000000;
        wrap_tab[3] = 21'h000001;
        for (int c = 1; c <= 24; c++) begin
            #1;
            check("boot_pwon_high", {31'b0, pwon_reset}, 32'd1);
            if (c >= 17) begin
                k = (c - 17) / 2;
                check("boot_addr", {11'b0, sram_addr_out}, 32'h00008FD5 + k);
                check("boot_we_n", {31'b0, sram_we_n_out}, 32'd1);
                check("wrap_addr", {11'b0, w_addr_out}, {11'b0, wrap_tab[k]});
            end
            @(negedge clk);
        end
        #1;
        check("boot_pwon_low", {31'b0, pwon_reset}, 32'd0);
        check("boot_busy_low", {31'b0, busy}, 32'd0);
        check("boot_config", config_out, 32'hFF5AA503);
        check("boot_vga_on", {31'b0, vga_on}, 32'd1);
        check("boot_scanlines_on", {31'b0, scanlines_on}, 32'd1);
    endtask

    initial begin
        logic [7:0] data_tab [4];
        int busy_cnt, lo_cnt, done_cnt, pw_bad;
        data_tab[0] = 8'h44;
        data_tab[1] = 8'h33;
        data_tab[2] = 8'h22;
        data_tab[3] = 8'h11;

        #1;
        check("rst_we_n", {31'b0, sram_we_n_out}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_pwon", {31'b0, pwon_reset}, 32'd1);
        check("rst_save_done", {31'b0, save_done}, 32'd0);
        check("rst_config", config_out, 32'h0);
        check("rst_addr", {11'b0, sram_addr_out}, 32'h00008FD5);

        @(negedge clk);
        rst = 1'b0;
        boot_check();

        sram_addr_in = 21'h1ABCDE;
        sram_we_n_in = 1'b0;
        sram_dout_in = 8'h5C;
        #1;
        check("pt_addr", {11'b0, sram_addr_out}, 32'h001ABCDE);
        check("pt_we_n", {31'b0, sram_we_n_out}, 32'd0);
        check("pt_dout", {24'b0, sram_dout_out}, 32'h5C);
        check("pt_busy", {31'b0, busy}, 32'd0);
        sram_we_n_in = 1'b1;

        @(negedge clk);
        save_data = 32'h11223344;
        save_req  = 1'b1;
        busy_cnt = 0; lo_cnt = 0; done_cnt = 0;
        for (int it = 0; it < 20; it++) begin
            #1;
            if (it == 1) check("save_latency_idle", {31'b0, busy}, 32'd0);
            if (it == 2) check("save_latency_busy", {31'b0, busy}, 32'd1);
            if (busy) busy_cnt++;
            if (!sram_we_n_out) begin
                check("save_addr", {11'b0, sram_addr_out}, 32'h00008FD5 + ((lo_cnt / 2) & 3));
                check("save_data", {24'b0, sram_dout_out}, {24'b0, data_tab[(lo_cnt / 2) & 3]});
                lo_cnt++;
            end
            if (save_done) done_cnt++;
            @(negedge clk);
            if (it == 0) save_req = 1'b0;
        end
        check("save_busy_cycles", busy_cnt, 32'd16);
        check("save_we_low_cycles", lo_cnt, 32'd8);
        check("save_done_pulses", done_cnt, 32'd1);
        check("save_config", config_out, 32'h11223344);
        check("save_pwon_low", {31'b0, pwon_reset}, 32'd0);

        save_data = 32'hAABBCCDD;
        save_req  = 1'b1;
        for (int it = 0; it < 11; it++) begin
            @(negedge clk);
            if (it == 0) save_req = 1'b0;
        end
        #1;
        check("midsave_pre_we_n", {31'b0, sram_we_n_out}, 32'd0);
        check("midsave_pre_addr", {11'b0, sram_addr_out}, 32'h00008FD7);
        rst = 1'b1;
        #1;
        check("midsave_rst_we_n", {31'b0, sram_we_n_out}, 32'd1);
        check("midsave_rst_config", config_out, 32'h0);
        check("midsave_rst_pwon", {31'b0, pwon_reset}, 32'd1);
        check("midsave_rst_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        boot_check();

        #1;
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        save_data = 32'h0F0E0D0C;
        pw_bad = 0;
        for (int c = 1; c <= 45; c++) begin
            #1;
            if (c == 24) check("bootsave_pwon_24", {31'b0, pwon_reset}, 32'd1);
            if (c == 25) check("bootsave_config_boot", config_out, 32'hFF5AA503);
            if (c == 26) check("bootsave_busy_start", {31'b0, busy}, 32'd1);
            if (c == 26) check("bootsave_config_snap", config_out, 32'h0F0E0D0C);
            if (c == 41) check("bootsave_busy_end", {31'b0, busy}, 32'd1);
            if (c == 42) check("bootsave_done", {31'b0, save_done}, 32'd1);
            if (c == 42) check("bootsave_idle", {31'b0, busy}, 32'd0);
            if (c >= 25 && pwon_reset) pw_bad++;
            @(negedge clk);
            if (c == 4) save_req = 1'b1;
            if (c == 5) save_req = 1'b0;
        end
        check("bootsave_pwon_stays_low", pw_bad, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
